// File: rtl/irq_pkg.sv
// Shared definitions for the irq_ctrl interrupt controller: register offsets,
// the register-select and bus-state enums, and the cause priority encoder.
package irq_pkg;

  localparam logic [2:0]  IRQ_OFS_PEND   = 3'h0;
  localparam logic [2:0]  IRQ_OFS_ENABLE = 3'h2;
  localparam logic [2:0]  IRQ_OFS_CAUSE  = 3'h4;
  localparam logic [2:0]  IRQ_OFS_MODE   = 3'h6;
  localparam logic [15:0] IRQ_CAUSE_NONE = 16'hFFFF;

  typedef enum logic [1:0] {RegPend, RegEnable, RegCause, RegMode} irq_reg_e;
  typedef enum logic {StIdle, StResp} irq_bus_e;

  // Index of the lowest set bit, or IRQ_CAUSE_NONE when the vector is empty.
  function automatic logic [15:0] irq_first_set(input logic [15:0] v);
    logic [15:0] idx;
    idx = IRQ_CAUSE_NONE;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 16'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sample.sv
// Per-source sampling: optional two-flop synchronizer (IRQ_CTRL_SYNC_EN), the
// sample flop and its previous value, giving the sampled level and a rise pulse.
module irq_sample #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] i_src,
  output logic [NUM_SRC-1:0] o_level,
  output logic [NUM_SRC-1:0] o_rise
);

  logic [NUM_SRC-1:0] w_in;
  logic [NUM_SRC-1:0] r_s;
  logic [NUM_SRC-1:0] r_s_prev;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = i_src;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s      <= '0;
      r_s_prev <= '0;
    end else begin
      r_s      <= w_in;
      r_s_prev <= r_s;
    end
  end

  assign o_level = r_s;
  assign o_rise  = r_s & ~r_s_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/enable/mode registers on a valid/ready slave
// bus and a registered trap output. Define IRQ_CTRL_SYNC_EN for async sources.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               trap,
  input  logic               mem_valid,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_wdata,
  input  logic [1:0]         mem_wstrb,
  output logic [15:0]        mem_rdata,
  output logic               mem_ready,
  output logic               mem_hit
);

  localparam logic [15:0] SrcMask = 16'((32'd1 << NUM_SRC) - 32'd1);

  irq_bus_e           r_state, w_state_d;
  irq_reg_e           w_sel;
  logic [15:0]        r_pend, r_enable, r_mode, r_rdata;
  logic [15:0]        w_pend_d, w_enable_d, w_mode_d, w_rdata;
  logic [15:0]        w_level, w_rise, w_bmask, w_wmerge, w_w1c, w_cause;
  logic [NUM_SRC-1:0] w_level_n, w_rise_n;
  logic               r_trap, w_accept, w_wr, w_unused;

  irq_sample #(
    .NUM_SRC(NUM_SRC)
  ) u_sample (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_src  (irq_src),
    .o_level(w_level_n),
    .o_rise (w_rise_n)
  );

  assign w_level  = 16'(w_level_n);
  assign w_rise   = 16'(w_rise_n);
  assign w_unused = mem_addr[0];

  assign mem_hit  = mem_valid && (mem_addr[15:3] == BASE_ADDR[15:3]);
  assign w_accept = (r_state == StIdle) && mem_hit;
  assign w_wr     = w_accept && (mem_wstrb != 2'b00);
  assign w_bmask  = {{8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign w_cause  = irq_first_set(r_pend & r_enable);

  always_comb begin
    w_sel = RegPend;
    case ({mem_addr[2:1], 1'b0})
      IRQ_OFS_PEND:   w_sel = RegPend;
      IRQ_OFS_ENABLE: w_sel = RegEnable;
      IRQ_OFS_CAUSE:  w_sel = RegCause;
      IRQ_OFS_MODE:   w_sel = RegMode;
      default:        w_sel = RegPend;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_sel)
      RegPend:   w_rdata = r_pend;
      RegEnable: w_rdata = r_enable;
      RegCause:  w_rdata = w_cause;
      RegMode:   w_rdata = r_mode;
      default:   w_rdata = '0;
    endcase
  end

  // W1C reaches edge-mode bits only; a rise in the same cycle still sets the bit.
  always_comb begin
    w_wmerge   = mem_wdata & w_bmask;
    w_w1c      = (w_wr && w_sel == RegPend) ? (w_wmerge & r_mode) : '0;
    w_pend_d   = ((r_mode & ((r_pend & ~w_w1c) | w_rise)) | (~r_mode & w_level)) & SrcMask;
    w_enable_d = r_enable;
    w_mode_d   = r_mode;
    if (w_wr && w_sel == RegEnable) w_enable_d = ((r_enable & ~w_bmask) | w_wmerge) & SrcMask;
    if (w_wr && w_sel == RegMode)   w_mode_d   = ((r_mode & ~w_bmask) | w_wmerge) & SrcMask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_enable <= '0;
      r_mode   <= '0;
      r_rdata  <= '0;
      r_trap   <= 1'b0;
    end else begin
      r_pend   <= w_pend_d;
      r_enable <= w_enable_d;
      r_mode   <= w_mode_d;
      r_trap   <= |(r_pend & r_enable);
      if (w_accept) r_rdata <= w_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (mem_hit) w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_ready = (r_state == StResp);
    mem_rdata = r_rdata;
    trap      = r_trap;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: per-cycle behavioural model comparison plus
// directed register/latency scenarios with literal expectations.
module tb_irq_ctrl;

  localparam int unsigned NSRC = 12;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] MASK = 16'h0FFF;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int STAGES = LAT - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] irq_src = '0;
  logic            trap;
  logic            mem_valid = 1'b0;
  logic [15:0]     mem_addr = '0;
  logic [15:0]     mem_wdata = '0;
  logic [1:0]      mem_wstrb = '0;
  logic [15:0]     mem_rdata;
  logic            mem_ready;
  logic            mem_hit;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl #(
    .NUM_SRC  (NSRC),
    .BASE_ADDR(BASE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .trap     (trap),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_hit  (mem_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sources delayed through STAGES samples, registers as plain vectors.
  logic [NSRC-1:0] m_stage [STAGES];
  logic [NSRC-1:0] m_prev;
  logic [15:0]     m_pend, m_en, m_mode, m_rdata;
  logic            m_ready, m_trap;

  function automatic logic model_hit();
    int d;
    d = int'(mem_addr) - int'(BASE);
    return mem_valid && d >= 0 && d <= 7;
  endfunction

  function automatic logic [15:0] model_cause(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 16'(i);
    return 16'hFFFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] s, rise, bm, w1c, np;
    logic        acc;
    int          off;
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) m_stage[k] <= '0;
      m_prev  <= '0;
      m_pend  <= '0;
      m_en    <= '0;
      m_mode  <= '0;
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_trap  <= 1'b0;
    end else begin
      s    = 16'(m_stage[STAGES-1]);
      rise = s & ~16'(m_prev);
      acc  = !m_ready && model_hit();
      off  = (int'(mem_addr) - int'(BASE)) & 6;
      bm   = {{8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
      w1c  = '0;
      if (acc) begin
        case (off)
          0:       m_rdata <= m_pend;
          2:       m_rdata <= m_en;
          4:       m_rdata <= model_cause(m_pend & m_en);
          default: m_rdata <= m_mode;
        endcase
        if (mem_wstrb != 2'b00) begin
          case (off)
            0:       w1c = mem_wdata & bm;
            2:       m_en <= ((m_en & ~bm) | (mem_wdata & bm)) & MASK;
            6:       m_mode <= ((m_mode & ~bm) | (mem_wdata & bm)) & MASK;
            default: ;
          endcase
        end
      end
      np = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        if (m_mode[i]) np[i] = rise[i] || (m_pend[i] && !w1c[i]);
        else           np[i] = s[i];
      end
      m_pend  <= np;
      m_trap  <= |(m_pend & m_en);
      m_ready <= acc;
      m_stage[0] <= irq_src;
      for (int k = 1; k < STAGES; k++) m_stage[k] <= m_stage[k-1];
      m_prev <= m_stage[STAGES-1];
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("cyc_trap", 16'(trap), 16'(m_trap));
      chk("cyc_ready", 16'(mem_ready), 16'(m_ready));
      chk("cyc_hit", 16'(mem_hit), 16'(model_hit()));
      if (m_ready) chk("cyc_rdata", mem_rdata, m_rdata);
    end
  end

  task automatic xfer(input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [1:0] strb, output logic [15:0] rd);
    bit got;
    got = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    rd        = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 2'b00;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL xfer_timeout: got no mem_ready expected mem_ready at addr %h", addr);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] rd;
    xfer(addr, data, 2'b11, rd);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] rd;
    xfer(addr, 16'h0000, 2'b00, rd);
    chk(name, rd, exp);
  endtask

  task automatic pulse(input logic [NSRC-1:0] bits);
    @(negedge clk);
    irq_src = irq_src | bits;
    @(negedge clk);
    irq_src = irq_src & ~bits;
  endtask

  initial begin
    logic [15:0] rd;
    repeat (3) @(negedge clk);
    chk("rst_trap", 16'(trap), 16'h0);
    chk("rst_ready", 16'(mem_ready), 16'h0);
    chk("rst_rdata", mem_rdata, 16'h0);
    rst_n = 1'b1;

    rd_chk("rst_pend", BASE + 16'h0, 16'h0000);
    rd_chk("rst_enable", BASE + 16'h2, 16'h0000);
    rd_chk("rst_cause", BASE + 16'h4, 16'hFFFF);
    rd_chk("rst_mode", BASE + 16'h6, 16'h0000);

    // Edge-mode source 0: latency, cause, W1C
    wr(BASE + 16'h6, 16'h0001);
    wr(BASE + 16'h2, 16'h0001);
    pulse(12'h001);
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk);
      #1;
      chk("lat_low", 16'(trap), 16'h0);
    end
    @(posedge clk);
    #1;
    chk("lat_high", 16'(trap), 16'h1);
    rd_chk("edge_pend", BASE + 16'h0, 16'h0001);
    rd_chk("edge_cause", BASE + 16'h4, 16'h0000);
    xfer(BASE + 16'h0, 16'h0001, 2'b11, rd);
    chk("w1c_trap_hold", 16'(trap), 16'h1);
    @(posedge clk);
    #1;
    chk("w1c_trap_fall", 16'(trap), 16'h0);

    // Priority between sources 5 and 2
    wr(BASE + 16'h6, 16'h00FF);
    wr(BASE + 16'h2, 16'h00FF);
    pulse(12'h024);
    repeat (LAT + 1) @(posedge clk);
    rd_chk("prio_cause2", BASE + 16'h4, 16'h0002);
    wr(BASE + 16'h0, 16'h0004);
    rd_chk("prio_cause5", BASE + 16'h4, 16'h0005);
    chk("prio_trap", 16'(trap), 16'h1);
    wr(BASE + 16'h0, 16'h0020);
    rd_chk("prio_empty", BASE + 16'h0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("prio_trap_off", 16'(trap), 16'h0);

    // Level mode on source 3
    wr(BASE + 16'h6, 16'h0000);
    wr(BASE + 16'h2, 16'h0008);
    @(negedge clk);
    irq_src[3] = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("lvl_trap", 16'(trap), 16'h1);
    wr(BASE + 16'h0, 16'h0008);
    rd_chk("lvl_w1c_ignored", BASE + 16'h0, 16'h0008);
    @(negedge clk);
    irq_src[3] = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    rd_chk("lvl_drop", BASE + 16'h0, 16'h0000);
    chk("lvl_trap_off", 16'(trap), 16'h0);

    // W1C colliding with a new rise on source 1
    wr(BASE + 16'h6, 16'h0002);
    wr(BASE + 16'h2, 16'h0002);
    pulse(12'h002);
    repeat (LAT + 1) @(posedge clk);
    rd_chk("col_pre", BASE + 16'h0, 16'h0002);
    @(negedge clk);
    irq_src[1] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    wr(BASE + 16'h0, 16'h0002);
    irq_src[1] = 1'b0;
    rd_chk("col_set_wins", BASE + 16'h0, 16'h0002);
    wr(BASE + 16'h0, 16'h0002);
    rd_chk("col_cleared", BASE + 16'h0, 16'h0000);

    // Outside the window
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + 16'h8;
    #1;
    chk("miss_hit_hi", 16'(mem_hit), 16'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("miss_ready_hi", 16'(mem_ready), 16'h0);
    end
    mem_addr = BASE - 16'h1;
    #1;
    chk("miss_hit_lo", 16'(mem_hit), 16'h0);
    @(posedge clk);
    #1;
    chk("miss_ready_lo", 16'(mem_ready), 16'h0);
    mem_valid = 1'b0;

    // Byte strobes, masking and odd addresses
    wr(BASE + 16'h2, 16'h0012);
    xfer(BASE + 16'h2, 16'hABCD, 2'b10, rd);
    rd_chk("bstrb_hi", BASE + 16'h2, 16'h0B12);
    xfer(BASE + 16'h3, 16'hABCD, 2'b01, rd);
    rd_chk("bstrb_lo_odd", BASE + 16'h3, 16'h0BCD);
    xfer(BASE + 16'h4, 16'h0003, 2'b11, rd);
    rd_chk("cause_ro", BASE + 16'h5, 16'hFFFF);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that sits directly upstream of the core's `trap` input. It collects up to 16 external interrupt sources, latches them as pending, and masks them with an enable register. While any enabled source is pending it drives `trap` high. Its registers are memory-mapped as a slave on the core's valid/ready memory bus, so the trap handler can read the cause and clear pending bits.

## Interface
Parameters:
- `NUM_SRC`, 8: number of interrupt sources, 1..16.
- `BASE_ADDR`, 16'hFF00: base of the 8-byte register window; must be 8-byte aligned.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `irq_src`  in  NUM_SRC  raw interrupt sources, asynchronous to `clk`.
- `trap`  out  1  interrupt request to the core; registered.
- `mem_valid`  in  1  core bus request.
- `mem_addr`  in  16  byte address.
- `mem_wdata`  in  16  write data.
- `mem_wstrb`  in  2  byte write strobes; 2'b00 means read.
- `mem_rdata`  out  16  read data; valid while `mem_ready` is high.
- `mem_ready`  out  1  one-cycle response pulse.
- `mem_hit`  out  1  combinational: `mem_valid` and `mem_addr` is inside the window; used by the bus mux to select this slave's `mem_rdata`/`mem_ready`.

## Operation
Registers, at BASE_ADDR + offset (bits at and above NUM_SRC read 0, writes to them ignored):
- 0x0 PEND: read returns pending bits. Write-1-to-clear applies to edge-mode bits only; writes to level-mode bits are ignored.
- 0x2 ENABLE: read/write; reset value 0.
- 0x4 CAUSE: read-only. Returns the index of the lowest-numbered set bit of PEND & ENABLE, or 16'hFFFF when none is set. Writes are ignored.
- 0x6 MODE: read/write; 1 = rising-edge, 0 = level; reset value 0.
- Odd byte addresses inside the window are aligned down to the even register.

Source path:
- Sampled level `s` = `irq_src` after the sample stage.
- Edge mode: a PEND bit sets when `s` & ~`s_prev`.
- Level mode: a PEND bit follows `s` every cycle.
- Same cycle, same bit, edge set and W1C: set wins.

Trap:
- `trap` <= |(PEND & ENABLE), registered.
- `trap` stays high until software clears or disables every enabled pending bit.

Bus:
- `mem_wstrb[0]` writes bits 7:0; `mem_wstrb[1]` writes bits 15:8.
- Each accepted request produces exactly one `mem_ready` pulse.

## Timing
- Reset values: `trap`=0, `mem_ready`=0, `mem_rdata`=0, PEND/ENABLE/MODE=0, sample/sync flops=0.
- Bus handshake:
  - If `mem_ready` is high, `mem_ready` goes low on the next edge.
  - Otherwise, if `mem_valid` and `mem_hit`, `mem_ready` goes high on the next edge.
  - So the response comes 1 cycle after request and the minimum spacing between accepts is 2 cycles.
  - The core holds `mem_valid`/`mem_addr`/`mem_wdata` until it sees `mem_ready`.
- The register write commits on the same edge that raises `mem_ready`.
- `mem_rdata` is captured on that edge from pre-write state; CAUSE is captured from that same state.
- Source-to-trap latency, source high before edge k, without sync: `s` at k, PEND at k+1, `trap` at k+2. With sync: `trap` at k+4.
- ENABLE write at edge k, with the bit already pending: `trap` changes at k+1.
- Reset asserted mid-transaction: `mem_ready` drops immediately and the transaction is lost; the core re-issues it after reset.

## Configuration
- `IRQ_CTRL_SYNC_EN` defined: two-flop synchronizer per source ahead of the sample flop; adds 2 cycles of latency.
- Not defined: single sample flop only; sources must already be synchronous to `clk`.

## Structure
- Package `irq_pkg`: register offset constants (`IRQ_OFS_PEND`, `IRQ_OFS_ENABLE`, `IRQ_OFS_CAUSE`, `IRQ_OFS_MODE`), `IRQ_CAUSE_NONE`=16'hFFFF, and a register-select enum.
- Sub-module `irq_sample`: one instance per source, or vectored. Contains the optional synchronizer, the sample flop and `s_prev`. Outputs `level` and `rise`.
- Top level holds the register file, the priority encoder, the bus FSM (IDLE/RESP) and the `trap` flop.

## Test plan
- Reset, then read all four registers: PEND=0, ENABLE=0, CAUSE=16'hFFFF, MODE=0; `trap`=0.
- MODE=0x0001, ENABLE=0x0001, pulse `irq_src[0]` for 1 cycle: `trap` rises at the stated latency, PEND=0x0001, CAUSE=0. Write PEND=0x0001: `trap` falls 1 cycle after `mem_ready`.
- ENABLE=0x00FF, edges on sources 5 and 2: CAUSE=2. Clear bit 2: CAUSE=5, `trap` stays 1.
- Level mode on source 3, held high, ENABLE=0x0008: write PEND=0x0008 and PEND still reads 0x0008. Drop the source: PEND=0, then `trap`=0.
- W1C on bit 1 on the same edge a new rise on source 1 is recorded: PEND bit 1 remains 1.
- Access outside the window: `mem_hit`=0, no `mem_ready`. Byte write with `mem_wstrb`=2'b10 of 16'hABCD to ENABLE when it holds 0x0012: ENABLE=0xAB12, masked to NUM_SRC bits.
